count_enable_prescaler: RTL and testbench
=========================================

# count_enable_prescaler

Programmable enable-pulse generator that sits directly upstream of the 16/32-bit synchronous up counters and drives their `enable` input. It turns a start/stop request into single-cycle `tick` pulses spaced `div+1` clocks apart. It runs either continuously or for a fixed burst of `burst_len` ticks. The counter then advances exactly once per tick.

## Interface
Parameters:
- `DIV_WIDTH`, 16, width of the prescale divider.
- `BURST_WIDTH`, 16, width of the burst-length field and remaining-tick counter.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin; sampled only in IDLE.
- `stop`  in  1  request to abort; sampled only in RUN.
- `mode`  in  1  0 = continuous, 1 = burst; latched at start.
- `div`  in  DIV_WIDTH  tick period minus one; latched at start.
- `burst_len`  in  BURST_WIDTH  ticks per burst (mode 1); latched at start.
- `tick`  out  1  one-cycle enable pulse to the downstream counter's `enable`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a burst completes normally.

## Operation
- Registers: `state` {IDLE, RUN}, `pcnt` (DIV_WIDTH), `rem` (BURST_WIDTH), `div_q`, `mode_q`, and `done` (registered).
- Reset: state=IDLE, pcnt=0, rem=0, done=0. Therefore tick=0 and busy=0.
- `tick` = (state==RUN) && (pcnt==0). It decodes registers only, with no combinational path from inputs. `busy` = (state==RUN).
- IDLE:
  - If `start` and not `stop`: latch div, mode and burst_len. Set pcnt<=div and rem<=burst_len. Go to RUN.
  - If `start` && `mode`==1 && `burst_len`==0: stay in IDLE, and done<=1 for one cycle. No ticks are emitted.
  - If `start` and `stop` are asserted together in IDLE, `stop` wins and the block stays in IDLE.
- RUN, evaluated at each edge, first match applies:
  - `stop`: go to IDLE. No done.
  - pcnt!=0: pcnt<=pcnt-1.
  - pcnt==0 (tick cycle) with mode_q=0: pcnt<=div_q.
  - pcnt==0 with mode_q=1 and rem!=1: pcnt<=div_q, rem<=rem-1.
  - pcnt==0 with mode_q=1 and rem==1: go to IDLE and set done<=1.
- `start` during RUN is ignored. Changes to `div`, `mode` or `burst_len` during RUN have no effect until the next start.
- div=0 gives a tick on every RUN cycle. Maximum div gives a period of 2^DIV_WIDTH cycles.
- `done` is cleared on every edge where it is not being set.

## Timing
- Cycle numbering: the `start` request is present in cycle 0 and sampled at the end of cycle 0.
  - busy=1 from cycle 1.
  - First tick in cycle 1+div.
  - Subsequent ticks every div+1 cycles.
- Burst: tick k (k=0..N-1) appears in cycle 1+div+k·(div+1). In the cycle after the last tick, done=1 and busy=0.
- A stop sampled at the end of cycle c puts the block in IDLE in cycle c+1. If cycle c was a tick cycle, that tick stands: the counter has already used it.
- Reset asserted mid-RUN returns the block to IDLE on the next edge. In the following cycle tick, busy and done are all 0, and the latched values are discarded.
- Latency from start to first tick is div+1 cycles. Throughput is one tick per div+1 cycles with no gap between consecutive bursts beyond one IDLE cycle.

## Test plan
- Reset with start held high: tick, busy and done stay 0 while reset=1. Release reset with start=1, mode=0, div=0: busy=1 from the next cycle and tick=1 on every following cycle.
- Continuous, div=3: first tick 4 cycles after the start edge, then ticks every 4 cycles. Assert stop on the 2nd tick cycle: that tick is present, busy drops next cycle, no further ticks, done stays 0.
- Burst, div=2, burst_len=5: exactly 5 ticks, at cycles 3, 6, 9, 12, 15. done=1 and busy=0 at cycle 16. A downstream 32-bit counter reads 5.
- Burst with burst_len=0: no ticks; done=1 for exactly one cycle after start; busy never rises.
- Start while busy, and div changed from 1 to 7 mid-run: ticks keep period 2 and the second start has no effect. start+stop together in IDLE leaves the block idle.
- Reset mid-burst (div=1, burst_len=10, reset after 3 ticks): the block is idle next cycle with no done. A fresh start produces 10 ticks.

Source files
------------

// File: rtl/count_enable_prescaler.sv
// count_enable_prescaler
//
// Produces single-cycle enable pulses for the downstream synchronous up
// counters. After a start request, the block emits a tick every div+1
// clocks. It runs either until stopped (continuous mode) or for exactly
// burst_len ticks (burst mode). At the end of a burst, a one-cycle done
// pulse is raised.
//
// Ports
//   clk        sole clock; all state changes on its rising edge
//   reset      synchronous, active-high reset
//   start      request to begin; only looked at while idle
//   stop       request to abort; only looked at while running
//   mode       0 = continuous, 1 = burst; captured at start
//   div        tick period minus one; captured at start
//   burst_len  number of ticks in a burst; captured at start
//   tick       one-cycle enable pulse for the downstream counter
//   busy       high while running
//   done       one-cycle pulse when a burst completes normally

module count_enable_prescaler #(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   tick,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DIV_WIDTH-1:0]   pcnt;
  logic [DIV_WIDTH-1:0]   pcnt_nxt;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   div_q_nxt;
  logic [BURST_WIDTH-1:0] rem;
  logic [BURST_WIDTH-1:0] rem_nxt;
  logic                   mode_q;
  logic                   mode_q_nxt;
  logic                   done_nxt;

  logic pcnt_zero;
  logic rem_last;
  logic empty_burst;

  assign pcnt_zero   = (pcnt == '0);
  assign rem_last    = (rem == BURST_WIDTH'(1));
  assign empty_burst = mode && (burst_len == '0);

  // Outputs decode registered state only, so the downstream enable never
  // sees a combinational path from the request inputs.
  assign busy = (state == RUN);
  assign tick = (state == RUN) && pcnt_zero;

  // State and datapath registers. The captured configuration is cleared on
  // reset as well, so nothing from an interrupted run survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pcnt   <= '0;
      rem    <= '0;
      div_q  <= '0;
      mode_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pcnt   <= pcnt_nxt;
      rem    <= rem_nxt;
      div_q  <= div_q_nxt;
      mode_q <= mode_q_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state and datapath logic.
  //
  // In RUN, pcnt counts down to zero. The zero cycle is the tick cycle,
  // and on that cycle the counter reloads from the captured divider. In
  // burst mode, rem holds the ticks still owed including the current one,
  // so the run ends when a tick is issued with rem == 1.
  //
  // stop takes priority over everything else in RUN. A tick already
  // present in the stop cycle has been seen by the counter and stands.
  //
  // A zero-length burst request is answered with done alone and never
  // enters RUN. This avoids rem wrapping and an unbounded burst.
  always_comb begin
    state_nxt  = state;
    pcnt_nxt   = pcnt;
    rem_nxt    = rem;
    div_q_nxt  = div_q;
    mode_q_nxt = mode_q;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (empty_burst) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt  = RUN;
            pcnt_nxt   = div;
            rem_nxt    = burst_len;
            div_q_nxt  = div;
            mode_q_nxt = mode;
          end
        end
      end

      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (!pcnt_zero) begin
          pcnt_nxt = pcnt - DIV_WIDTH'(1);
        end else if (!mode_q) begin
          pcnt_nxt = div_q;
        end else if (!rem_last) begin
          pcnt_nxt = div_q;
          rem_nxt  = rem - BURST_WIDTH'(1);
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_count_enable_prescaler.sv
// tb_count_enable_prescaler
//
// Drives directed scenarios followed by a randomized run. Every cycle, the
// DUT's tick/busy/done are compared with a reference model. The model does
// not count down a prescaler. Instead, it remembers the cycle a run began
// and derives tick positions arithmetically: tick k is at
// run_start + div + k*(div+1).

module tb_count_enable_prescaler;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        mode;
  logic [15:0] div;
  logic [15:0] burst_len;
  logic        tick;
  logic        busy;
  logic        done;

  int          vectors;
  int          miscompares;
  longint      cyc;

  // Reference model state.
  bit          m_run;
  bit          m_done;
  bit          m_mode;
  longint      m_run_start;
  longint      m_div;
  longint      m_len;

  // Downstream counter and done-pulse tally, used for whole-scenario checks.
  int          ds_count;
  int          done_count;

  count_enable_prescaler #(
    .DIV_WIDTH   (16),
    .BURST_WIDTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .div       (div),
    .burst_len (burst_len),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the model and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               tag, cyc, observed, expected);
    end
  endtask

  // The model ticks when the run has lasted at least div cycles past its
  // start and the offset is a whole number of periods.
  function automatic bit model_tick();
    longint e;
    if (!m_run) return 1'b0;
    e = cyc - m_run_start - m_div;
    return (e >= 0) && ((e % (m_div + 1)) == 0);
  endfunction

  function automatic longint model_tick_index();
    return (cyc - m_run_start - m_div) / (m_div + 1);
  endfunction

  task automatic model_update(input bit r, input bit st, input bit sp,
                              input bit md, input int dv, input int bl);
    bit     t;
    longint k;
    t = model_tick();
    k = model_tick_index();
    if (r) begin
      m_run  = 1'b0;
      m_done = 1'b0;
    end else if (!m_run) begin
      m_done = st && !sp && md && (bl == 0);
      if (st && !sp && !(md && (bl == 0))) begin
        m_run       = 1'b1;
        m_run_start = cyc + 1;
        m_div       = dv;
        m_mode      = md;
        m_len       = bl;
      end
    end else begin
      m_done = 1'b0;
      if (sp) begin
        m_run = 1'b0;
      end else if (t && m_mode && (k == m_len - 1)) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  // One clock cycle: present inputs, let the edge happen, then compare the
  // new outputs with the model away from the edge.
  task automatic applyStimulus(input bit r, input bit st, input bit sp,
                               input bit md, input int dv, input int bl);
    reset     = r;
    start     = st;
    stop      = sp;
    mode      = md;
    div       = 16'(dv);
    burst_len = 16'(bl);
    @(posedge clk);
    model_update(r, st, sp, md, dv, bl);
    cyc++;
    @(negedge clk);
    if (tick === 1'b1) ds_count++;
    if (done === 1'b1) done_count++;
    checkOutput("tick", 32'(tick), 32'(model_tick()));
    checkOutput("busy", 32'(busy), 32'(m_run));
    checkOutput("done", 32'(done), 32'(m_done));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int base;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    m_run       = 1'b0;
    m_done      = 1'b0;
    m_mode      = 1'b0;
    m_run_start = 0;
    m_div       = 0;
    m_len       = 0;
    ds_count    = 0;
    done_count  = 0;
    reset       = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    mode        = 1'b0;
    div         = '0;
    burst_len   = '0;

    // Reset held with start high, then release straight into div=0 running.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    idle_cycles(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle_cycles(2);

    // Continuous div=3, stop on the second tick cycle.
    base = ds_count;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
    idle_cycles(8);
    checkOutput("cont_stop_ticks", 32'(ds_count - base), 32'd2);

    // Burst div=2, burst_len=5.
    base       = ds_count;
    done_count = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2, 5);
    idle_cycles(20);
    checkOutput("burst5_ticks", 32'(ds_count - base), 32'd5);
    checkOutput("burst5_done", 32'(done_count), 32'd1);

    // Zero-length burst.
    base       = ds_count;
    done_count = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4, 0);
    idle_cycles(6);
    checkOutput("burst0_ticks", 32'(ds_count - base), 32'd0);
    checkOutput("burst0_done", 32'(done_count), 32'd1);

    // Start held during a run while div changes from 1 to 7.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 7, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7, 0);
    idle_cycles(2);

    // start together with stop in idle.
    base = ds_count;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    idle_cycles(4);
    checkOutput("start_stop_ticks", 32'(ds_count - base), 32'd0);

    // Reset after three ticks of a ten-tick burst, then a fresh burst.
    done_count = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1, 10);
    idle_cycles(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    idle_cycles(2);
    checkOutput("reset_mid_done", 32'(done_count), 32'd0);
    base = ds_count;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1, 10);
    idle_cycles(25);
    checkOutput("fresh_burst_ticks", 32'(ds_count - base), 32'd10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 31) == 0,
                    1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
